nios2_c_gpio_ext: RTL

Parametrised Avalon-MM general-purpose I/O port for the nios2_c system, and the successor to the fixed 4-bit output-only PIO. It provides per-bit direction control, a synchronised input path, atomic set and clear registers, edge capture with a maskable interrupt, and a hardware timed-pulse register. It sits on the processor's data master as a single 8-word slave, and its pins are exported to the top level.

---
 rtl/nios2_c_gpio_ext.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nios2_c_gpio_ext.sv
// Avalon-MM GPIO port: direction control, synchronised inputs, atomic set/clear,
// edge capture with maskable irq, and a hardware timed pulse that inverts selected outputs.

module nios2_c_gpio_ext_bit #(
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  input  logic i_cap_clr,
  output logic o_sync,
  output logic o_cap
);
  logic r_s1, r_s2, r_prev, r_cap;
  logic w_edge;

  always_comb begin
    w_edge = 1'b0;
    case (EDGE_TYPE)
      0:       w_edge = r_s2 & ~r_prev;
      1:       w_edge = ~r_s2 & r_prev;
      default: w_edge = r_s2 ^ r_prev;
    endcase
  end

  // A new edge takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_cap  <= 1'b0;
    end else begin
      r_s1   <= i_pin;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_cap  <= (r_cap & ~i_cap_clr) | w_edge;
    end
  end

  assign o_sync = r_s2;
  assign o_cap  = r_cap;
endmodule

module nios2_c_gpio_ext #(
  parameter int          WIDTH       = 4,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          PULSE_LEN   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  localparam logic [15:0] PLEN   = 16'(PULSE_LEN);
  localparam logic [31:0] ID_VAL = {16'h0, 8'(WIDTH), 8'h01};

  localparam logic [2:0] A_DATA = 3'd0, A_DIR = 3'd1, A_MASK = 3'd2, A_CAP = 3'd3,
                         A_SET  = 3'd4, A_CLR = 3'd5, A_PULSE = 3'd6, A_ID = 3'd7;

  logic [WIDTH-1:0] r_data_out, r_dir, r_irq_mask, r_pmask;
  logic [15:0]      r_cnt;
  logic [WIDTH-1:0] w_wd, w_sync, w_cap, w_cap_clr;
  logic             w_wr, w_pulse_ld, w_unused;
  logic [31:0]      w_rd;

  assign w_wr       = chipselect & ~write_n;
  assign w_wd       = writedata[WIDTH-1:0];
  assign w_unused   = |writedata;
  assign w_cap_clr  = (w_wr && address == A_CAP) ? w_wd : '0;
  assign w_pulse_ld = w_wr && (address == A_PULSE) && (|w_wd);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    nios2_c_gpio_ext_bit #(.EDGE_TYPE(EDGE_TYPE)) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_pin     (in_port[g]),
      .i_cap_clr (w_cap_clr[g]),
      .o_sync    (w_sync[g]),
      .o_cap     (w_cap[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_VALUE[WIDTH-1:0];
      r_dir      <= '0;
      r_irq_mask <= '0;
    end else if (w_wr) begin
      case (address)
        A_DATA:  r_data_out <= w_wd;
        A_DIR:   r_dir      <= w_wd;
        A_MASK:  r_irq_mask <= w_wd;
        A_SET:   r_data_out <= r_data_out | w_wd;
        A_CLR:   r_data_out <= r_data_out & ~w_wd;
        default: ;
      endcase
    end
  end

  // Reload beats expiry: a write landing on the final count keeps only the new bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pmask <= '0;
      r_cnt   <= '0;
    end else if (w_pulse_ld) begin
      r_cnt   <= PLEN;
      r_pmask <= ((r_cnt == 16'd1) ? '0 : r_pmask) | w_wd;
    end else if (r_cnt != 16'd0) begin
      r_cnt <= r_cnt - 16'd1;
      if (r_cnt == 16'd1) r_pmask <= '0;
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      A_DATA:  w_rd[WIDTH-1:0] = (r_data_out & r_dir) | (w_sync & ~r_dir);
      A_DIR:   w_rd[WIDTH-1:0] = r_dir;
      A_MASK:  w_rd[WIDTH-1:0] = r_irq_mask;
      A_CAP:   w_rd[WIDTH-1:0] = w_cap;
      A_PULSE: w_rd[WIDTH-1:0] = r_pmask;
      A_ID:    w_rd            = ID_VAL;
      default: w_rd            = '0;
    endcase
  end

  assign readdata = w_rd;
  assign out_port = r_data_out ^ r_pmask;
  assign oe       = r_dir;
  assign irq      = |(w_cap & r_irq_mask);
endmodule
